hazard_seq_ctrl: RTL

HAZARD_SEQ_CTRL -- requirements
Module: hazard_seq_ctrl

---
 rtl/hazard_seq_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/hazard_seq_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, branch flushes and data-memory waits
// with timeout recovery, plus saturating stall/flush event counters.
module hazard_seq_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       IF_ID_RegRs1,
  input  logic [4:0]       IF_ID_RegRs2,
  input  logic             IF_ID_UseRs2,
  input  logic             ID_EX_MemR,
  input  logic [4:0]       ID_EX_RegRd,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             EX_MEM_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             MEM_WB_Bubble,
  output logic             stall,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    MEM_WAIT    = 2'd1,
    ERR_RECOVER = 2'd2
  } state_t;

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state_q;
  state_t            state_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              mem_busy;
  logic              lu_stall;
  logic              timeout_hit;

  // Memory handshake: an access is outstanding while dmem_req is high and
  // dmem_ready is low; it completes in the cycle dmem_ready is seen high.
  assign load_use = ID_EX_MemR && (ID_EX_RegRd != 5'd0) &&
                    ((ID_EX_RegRd == IF_ID_RegRs1) ||
                     (IF_ID_UseRs2 && (ID_EX_RegRd == IF_ID_RegRs2)));
  assign mem_busy = dmem_req && !dmem_ready;
  assign state_dbg = state_q;

  always_comb begin
    state_d       = state_q;
    PC_Write      = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Write   = 1'b1;
    EX_MEM_Write  = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Flush   = 1'b0;
    MEM_WB_Bubble = 1'b0;
    lu_stall      = 1'b0;
    timeout_hit   = 1'b0;
    // Held in reset, the pipeline sees the plain RUN/no-event controls.
    if (rst_n) begin
      case (state_q)
        RUN: begin
          if (mem_busy) begin
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Write  = 1'b0;
            MEM_WB_Bubble = 1'b1;
            state_d       = MEM_WAIT;
          end else if (branch_taken) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
          end else if (load_use) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
            lu_stall    = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (dmem_ready) begin
            state_d = RUN;
          end else begin
            PC_Write      = 1'b0;
            IF_ID_Write   = 1'b0;
            ID_EX_Write   = 1'b0;
            EX_MEM_Write  = 1'b0;
            MEM_WB_Bubble = 1'b1;
            if (wait_cnt == WAIT_LAST) begin
              state_d     = ERR_RECOVER;
              timeout_hit = 1'b1;
            end
          end
        end
        ERR_RECOVER: begin
          // Flush the front end and bubble MEM/WB so the aborted access never retires.
          IF_ID_Flush   = 1'b1;
          ID_EX_Flush   = 1'b1;
          MEM_WB_Bubble = 1'b1;
          state_d       = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      stall    <= 1'b0;
      mem_err  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state_q  <= state_d;
      stall    <= lu_stall;
      mem_err  <= mem_err | timeout_hit;
      wait_cnt <= (state_q == MEM_WAIT) ? wait_cnt + WAIT_W'(1) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!PC_Write && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (IF_ID_Flush && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule
